// File: rtl/seven_seg_scan_controller.sv
// Scan controller for the 4-digit seven-segment display: walks three digit slots with a
// blanking lead-in per slot and double-buffers the displayed nibbles at frame boundaries.

module seven_seg_digit_lane #(
    parameter int VEC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             commit,
    input  logic [VEC_W-1:0] din,
    output logic [VEC_W-1:0] dout
);

    logic [VEC_W-1:0] staging;

    // commit reads the old staging value, so a load in the same cycle is held for the next commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            staging <= '0;
            dout    <= '0;
        end else begin
            if (commit)
                dout <= staging;
            if (load)
                staging <= din;
        end
    end

endmodule

module seven_seg_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       load,
    input  logic [3:0] opCode,
    input  logic [3:0] lowerBits,
    input  logic [3:0] upperBits,
    output logic [3:0] anode,
    output logic [3:0] opCodeOut,
    output logic [3:0] lowerBitsOut,
    output logic [3:0] upperBitsOut,
    output logic       pending,
    output logic       frame_done
);

    localparam int NUM_LANES = 3;
    localparam int VEC_W     = 4;
    localparam int CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    generate
        if (REFRESH_DIV < 2) begin : g_bad_div
            $error("REFRESH_DIV must be at least 2");
        end
        if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
            $error("BLANK_CYCLES must lie in [0, REFRESH_DIV)");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       slot, slot_nxt;
    logic             commit;

    logic [NUM_LANES-1:0][VEC_W-1:0] din;
    logic [NUM_LANES-1:0][VEC_W-1:0] dout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            slot  <= slot_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        slot_nxt   = slot;
        anode      = 4'b1111;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                slot_nxt = '0;
                if (enable)
                    state_nxt = SCAN;
            end
            SCAN: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    slot_nxt  = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt  = '0;
                    slot_nxt = (slot == 2'd2) ? 2'd0 : slot + 2'd1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
                // digit position 1 (4'b1101) is unpopulated and never selected
                if (int'(cnt) >= BLANK_CYCLES) begin
                    case (slot)
                        2'd0:    anode = 4'b1110;
                        2'd1:    anode = 4'b1011;
                        default: anode = 4'b0111;
                    endcase
                end
                frame_done = (slot == 2'd2) && (cnt == CNT_LAST);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // while dark there is nothing to tear, so staged data goes straight through
    assign commit = pending && ((state == IDLE) || frame_done);

    always_ff @(posedge clk) begin
        if (!rst_n)
            pending <= 1'b0;
        else if (load)
            pending <= 1'b1;
        else if (commit)
            pending <= 1'b0;
    end

    assign din = {upperBits, lowerBits, opCode};

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            seven_seg_digit_lane #(.VEC_W(VEC_W)) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (load),
                .commit (commit),
                .din    (din[g]),
                .dout   (dout[g])
            );
        end
    endgenerate

    assign opCodeOut    = dout[0];
    assign lowerBitsOut = dout[1];
    assign upperBitsOut = dout[2];

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Bench for seven_seg_scan_controller: vector table, hand-written corner sequences and a
// randomized run against an elapsed-time reference model.

module tb_seven_seg_scan_controller;

    localparam int RD = 8;
    localparam int BL = 2;

    logic       clk = 1'b0;
    logic       rst_n, enable, load;
    logic [3:0] opCode, lowerBits, upperBits;
    logic [3:0] anode, opCodeOut, lowerBitsOut, upperBitsOut;
    logic       pending, frame_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seven_seg_scan_controller #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .load         (load),
        .opCode       (opCode),
        .lowerBits    (lowerBits),
        .upperBits    (upperBits),
        .anode        (anode),
        .opCodeOut    (opCodeOut),
        .lowerBitsOut (lowerBitsOut),
        .upperBitsOut (upperBitsOut),
        .pending      (pending),
        .frame_done   (frame_done)
    );

    // reference model: scan position is just the number of cycles spent scanning
    bit          m_scan;
    int          m_t;
    logic [11:0] m_stage, m_comm;
    bit          m_pend;

    function automatic bit m_fd();
        return m_scan && ((m_t % (3 * RD)) == 3 * RD - 1);
    endfunction

    function automatic logic [3:0] m_anode();
        if (!m_scan || (m_t % RD) < BL)
            return 4'hF;
        case ((m_t / RD) % 3)
            0:       return 4'hE;
            1:       return 4'hB;
            default: return 4'h7;
        endcase
    endfunction

    task automatic model_upd();
        if (!rst_n) begin
            m_scan = 0; m_t = 0; m_stage = '0; m_comm = '0; m_pend = 0;
        end else begin
            bit fd;
            fd = m_fd();
            if (m_pend && (!m_scan || fd)) begin
                m_comm = m_stage;
                m_pend = 0;
            end
            if (load) begin
                m_stage = {opCode, lowerBits, upperBits};
                m_pend  = 1;
            end
            if (enable) begin
                if (m_scan) m_t++;
                else        m_t = 0;
                m_scan = 1;
            end else begin
                m_scan = 0;
                m_t    = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("mdl_anode", {8'h0, anode}, {8'h0, m_anode()});
        chk("mdl_frame_done", {11'h0, frame_done}, {11'h0, m_fd()});
        chk("mdl_pending", {11'h0, pending}, {11'h0, m_pend});
        chk("mdl_outputs", {opCodeOut, lowerBitsOut, upperBitsOut}, m_comm);
    endtask

    task automatic step(input logic r, input logic e, input logic l,
                        input logic [3:0] o, input logic [3:0] lo, input logic [3:0] u);
        @(negedge clk);
        rst_n = r; enable = e; load = l;
        opCode = o; lowerBits = lo; upperBits = u;
        #1;
        check_model();
        @(posedge clk);
        model_upd();
    endtask

    typedef struct {
        logic        r, e, l;
        logic [3:0]  o, lo, u;
        logic [3:0]  an;
        logic        fd, pd;
        logic [11:0] out;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic [3:0] pat [3];
        vec_t v;
        pat = '{4'hE, 4'hB, 4'h7};

        // reset rows with enable and load asserted, then the release cycle (still dark)
        for (int i = 0; i < 3; i++) begin
            v = '{r:1'b0, e:1'b1, l:1'b1, o:4'h5, lo:4'h6, u:4'h7,
                  an:4'hF, fd:1'b0, pd:1'b0, out:12'h000};
            vt.push_back(v);
        end
        v = '{r:1'b1, e:1'b1, l:1'b0, o:4'h0, lo:4'h0, u:4'h0,
              an:4'hF, fd:1'b0, pd:1'b0, out:12'h000};
        vt.push_back(v);
        // two full frames, load A/3/F at cycle 5
        for (int c = 0; c < 48; c++) begin
            v.r  = 1'b1; v.e = 1'b1; v.l = (c == 5);
            v.o  = (c == 5) ? 4'hA : 4'h0;
            v.lo = (c == 5) ? 4'h3 : 4'h0;
            v.u  = (c == 5) ? 4'hF : 4'h0;
            v.an  = ((c % 8) < 2) ? 4'hF : pat[(c / 8) % 3];
            v.fd  = (c == 23) || (c == 47);
            v.pd  = (c >= 6) && (c <= 23);
            v.out = (c >= 24) ? 12'hA3F : 12'h000;
            vt.push_back(v);
        end

        rst_n = 1'b0; enable = 1'b0; load = 1'b0;
        opCode = '0; lowerBits = '0; upperBits = '0;
        repeat (2) @(posedge clk);
        model_upd();

        foreach (vt[i]) begin
            @(negedge clk);
            rst_n = vt[i].r; enable = vt[i].e; load = vt[i].l;
            opCode = vt[i].o; lowerBits = vt[i].lo; upperBits = vt[i].u;
            #1;
            chk($sformatf("vec%0d_anode", i), {8'h0, anode}, {8'h0, vt[i].an});
            chk($sformatf("vec%0d_frame_done", i), {11'h0, frame_done}, {11'h0, vt[i].fd});
            chk($sformatf("vec%0d_pending", i), {11'h0, pending}, {11'h0, vt[i].pd});
            chk($sformatf("vec%0d_outputs", i), {opCodeOut, lowerBitsOut, upperBitsOut}, vt[i].out);
            @(posedge clk);
            model_upd();
        end

        // boundary collision: load at cycle 10, another load exactly on the boundary
        for (int c = 0; c < 48; c++) begin
            if (c == 10)      step(1, 1, 1, 4'h1, 4'h2, 4'h3);
            else if (c == 23) step(1, 1, 1, 4'h4, 4'h5, 4'h6);
            else              step(1, 1, 0, 4'h0, 4'h0, 4'h0);
            #1;
            if (c == 23) begin
                chk("collide_first_commit", {opCodeOut, lowerBitsOut, upperBitsOut}, 12'h123);
                chk("collide_pending_kept", {11'h0, pending}, 12'h001);
            end
            if (c == 47) begin
                chk("collide_second_commit", {opCodeOut, lowerBitsOut, upperBitsOut}, 12'h456);
                chk("collide_pending_clear", {11'h0, pending}, 12'h000);
            end
        end

        // load while dark: staged at edge N, committed at N+1
        step(1, 0, 0, 4'h0, 4'h0, 4'h0);
        step(1, 0, 1, 4'h7, 4'h8, 4'h9);
        #1;
        chk("idle_pending_set", {11'h0, pending}, 12'h001);
        chk("idle_dark_n", {8'h0, anode}, 12'h00F);
        step(1, 0, 0, 4'h0, 4'h0, 4'h0);
        #1;
        chk("idle_commit", {opCodeOut, lowerBitsOut, upperBitsOut}, 12'h789);
        chk("idle_pending_clear", {11'h0, pending}, 12'h000);
        chk("idle_dark_n1", {8'h0, anode}, 12'h00F);

        // mid-frame abort at cycle 13, then restart from slot 0
        step(1, 1, 0, 4'h0, 4'h0, 4'h0);
        for (int c = 0; c < 14; c++)
            step(1, (c != 13), 0, 4'h0, 4'h0, 4'h0);
        #1;
        chk("abort_dark", {8'h0, anode}, 12'h00F);
        step(1, 0, 0, 4'h0, 4'h0, 4'h0);
        step(1, 1, 0, 4'h0, 4'h0, 4'h0);
        #1;
        chk("restart_blank0", {8'h0, anode}, 12'h00F);
        step(1, 1, 0, 4'h0, 4'h0, 4'h0);
        #1;
        chk("restart_blank1", {8'h0, anode}, 12'h00F);
        step(1, 1, 0, 4'h0, 4'h0, 4'h0);
        #1;
        chk("restart_slot0", {8'h0, anode}, 12'h00E);
        for (int c = 2; c <= 30; c++)
            step((c != 30), 1, (c == 26), 4'hC, 4'hD, 4'hE);
        #1;
        chk("rst_anode", {8'h0, anode}, 12'h00F);
        chk("rst_outputs", {opCodeOut, lowerBitsOut, upperBitsOut}, 12'h000);
        chk("rst_pending", {11'h0, pending}, 12'h000);
        chk("rst_frame_done", {11'h0, frame_done}, 12'h000);
        step(1, 0, 0, 4'h0, 4'h0, 4'h0);

        // randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 5) == 0),
                 4'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
